// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared constants and types for the memory-access stage. It holds the bus
//   widths, the ld_type encodings, and the packed layouts of the
//   execute-to-memory and memory-to-write-back buses.
//   Optional feature macro used by importers: MS_RDATA_HOLD_EN.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 77;
  localparam int MS_TO_WS_BUS_WD = 70;

  // Load type encodings. Codes 101..111 are unassigned and behave as ld.w.
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Execute-to-memory bus. Fields are listed MSB first.
  typedef struct packed {
    logic        res_from_mem;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [1:0]  st_type;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        inst_no_dest;
  } es_to_ms_t;

  // Memory-to-write-back bus. Fields are listed MSB first.
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
//   Combinational load extraction. It picks the byte or half-word addressed
//   by addr out of the SRAM word, then sign- or zero-extends it according
//   to ld_type.
//   Ports:
//     rdata     in  32  raw SRAM word
//     addr      in  2   low address bits (alu_result[1:0])
//     ld_type   in  3   load type encoding
//     load_data out 32  extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Half-word loads ignore addr[0].
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (ld_type)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {24'd0, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage of the five-stage pipeline. It latches the
//   execute-to-memory bus, extracts and extends load data from the SRAM
//   read port, forwards dest/result to decode for bypassing, and hands the
//   final result to write-back under a valid/allowin handshake.
//   Ports:
//     clk                 in  1   clock, rising edge
//     resetn              in  1   asynchronous active-low reset
//     ws_allowin          in  1   write-back can accept
//     ms_allowin          out 1   this stage can accept
//     es_to_ms_valid      in  1   execute offers an instruction
//     es_to_ms_bus        in  77  execute-to-memory bus
//     data_sram_rdata     in  32  SRAM data for the address issued last cycle
//     ms_to_ws_valid      out 1   instruction offered to write-back
//     ms_to_ws_bus        out 70  {gr_we, dest, final_result, pc}
//     ms_to_ds_dest       out 5   bypass destination (0 when none)
//     ms_to_ds_result     out 32  bypass value
//     debug_ms_pc         out 32  latched pc
//     debug_ms_load_data  out 32  extended load data
//   Macro MS_RDATA_HOLD_EN: when defined, the SRAM word is captured in the
//   instruction's first cycle, so a stall of any length keeps the load result
//   stable. When undefined, data_sram_rdata is always used directly.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_result,
  output logic [31:0]                debug_ms_pc,
  output logic [31:0]                debug_ms_load_data
);

  logic        ms_valid_reg;
  es_to_ms_t   bus_reg;
  logic        ms_ready_go;
  logic        accept;
  logic [31:0] rdata_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;
  ms_to_ws_t   ws_bus;
  logic        unused_st_type;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;

  // A bubble clears ms_valid but leaves the bus register untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_reg <= 1'b0;
      bus_reg      <= '0;
    end else begin
      if (ms_allowin) ms_valid_reg <= es_to_ms_valid;
      if (accept)     bus_reg      <= es_to_ms_t'(es_to_ms_bus);
    end
  end

`ifdef MS_RDATA_HOLD_EN
  logic        ms_first_reg;
  logic [31:0] rdata_hold_reg;

  // ms_first marks the single cycle in which the SRAM word for this
  // instruction is present on data_sram_rdata. It drops after one edge,
  // whether the instruction stalls or leaves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_first_reg   <= 1'b0;
      rdata_hold_reg <= 32'd0;
    end else begin
      ms_first_reg <= accept;
      if (ms_first_reg) rdata_hold_reg <= data_sram_rdata;
    end
  end

  assign rdata_sel = ms_first_reg ? data_sram_rdata : rdata_hold_reg;
`else
  assign rdata_sel = data_sram_rdata;
`endif

  load_align u_load_align (
    .rdata     (rdata_sel),
    .addr      (bus_reg.alu_result[1:0]),
    .ld_type   (bus_reg.ld_type),
    .load_data (load_data)
  );

  assign final_result = bus_reg.res_from_mem ? load_data : bus_reg.alu_result;

  assign ws_bus.gr_we        = bus_reg.gr_we;
  assign ws_bus.dest         = bus_reg.dest;
  assign ws_bus.final_result = final_result;
  assign ws_bus.pc           = bus_reg.pc;
  assign ms_to_ws_bus        = ws_bus;

  // The result is ready in this stage, so decode can bypass loads
  // without stalling.
  assign ms_to_ds_dest      = bus_reg.dest & {5{ms_valid_reg & ~bus_reg.inst_no_dest}};
  assign ms_to_ds_result    = final_result;
  assign debug_ms_pc        = bus_reg.pc;
  assign debug_ms_load_data = load_data;

  // Store type travels with the instruction but has no role here.
  assign unused_st_type = ^bus_reg.st_type;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Self-checking bench for mem_stage. It applies directed load/non-load
//   vectors, stall, back-to-back and async-reset scenarios, and randomized
//   traffic. A behavioural occupancy/value model decides the expected outputs.
//   Honours MS_RDATA_HOLD_EN for the expected data source during stalls.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [76:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_result;
  logic [31:0] debug_ms_pc;
  logic [31:0] debug_ms_load_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                (clk),
    .resetn             (resetn),
    .ws_allowin         (ws_allowin),
    .ms_allowin         (ms_allowin),
    .es_to_ms_valid     (es_to_ms_valid),
    .es_to_ms_bus       (es_to_ms_bus),
    .data_sram_rdata    (data_sram_rdata),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus),
    .ms_to_ds_dest      (ms_to_ds_dest),
    .ms_to_ds_result    (ms_to_ds_result),
    .debug_ms_pc        (debug_ms_pc),
    .debug_ms_load_data (debug_ms_load_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: which instruction occupies the stage and which SRAM word it saw.
  logic        m_valid;
  logic        m_first;
  logic [76:0] m_bus;
  logic [31:0] m_data;
  logic [31:0] out_q[$];

  function automatic logic [76:0] mk(input logic res, input logic [2:0] ld, input logic we,
                                     input logic [1:0] st, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc,
                                     input logic nd);
    return {res, ld, we, st, dest, alu, pc, nd};
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input int addr, input int ld);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * addr)) & 32'hFF;
    h = (w >> (16 * (addr / 2))) & 32'hFFFF;
    case (ld)
      1:       return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3:       return b;
      2:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      4:       return h;
      default: return w;
    endcase
  endfunction

  // SRAM word that the current instruction's load should use.
  function automatic logic [31:0] m_src();
`ifdef MS_RDATA_HOLD_EN
    return m_first ? data_sram_rdata : m_data;
`else
    return data_sram_rdata;
`endif
  endfunction

  function automatic logic [31:0] m_load();
    return exp_load(m_src(), int'(m_bus[34:33]), int'(m_bus[75:73]));
  endfunction

  function automatic logic [31:0] m_final();
    return m_bus[76] ? m_load() : m_bus[64:33];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_first = 1'b0;
    m_bus   = '0;
    m_data  = '0;
  endtask

  // Advance one clock. Record DUT handoffs and update the model.
  task automatic tick();
    logic acc;
    logic take;
    logic [31:0] rd_now;
    acc    = !m_valid || ws_allowin;
    take   = es_to_ms_valid && acc;
    rd_now = data_sram_rdata;
    if (ms_to_ws_valid && ws_allowin) out_q.push_back(ms_to_ws_bus[31:0]);
    @(posedge clk);
    if (m_valid && m_first) m_data = rd_now;
    if (acc)  m_valid = es_to_ms_valid;
    if (take) m_bus   = es_to_ms_bus;
    m_first = take;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; ws_allowin = 1'b0; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL reset ms_allowin got %b want 1", ms_allowin); end
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL reset ms_to_ws_valid got %b want 0", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ds_dest !== 5'd0) begin n_err++; $display("FAIL reset ms_to_ds_dest got %h want 0", ms_to_ds_dest); end
    n_cmp++; if (ms_to_ws_bus !== 70'd0) begin n_err++; $display("FAIL reset ms_to_ws_bus got %h want 0", ms_to_ws_bus); end
    n_cmp++; if ({ms_to_ds_result, debug_ms_pc, debug_ms_load_data} !== 96'd0) begin
      n_err++; $display("FAIL reset result/debug got %h %h %h want 0", ms_to_ds_result, debug_ms_pc, debug_ms_load_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_load_vectors();
    logic [2:0]  v_ld[6]  = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b000, 3'b110};
    logic [1:0]  v_ad[6]  = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] v_rd[6]  = '{32'h1280_FF34, 32'h1280_FF34, 32'h8001_7FFF, 32'h8001_7FFF,
                              32'hCAFE_F00D, 32'h1122_3344};
    logic [31:0] v_exp[6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8001, 32'h0000_7FFF,
                              32'hCAFE_F00D, 32'h1122_3344};
    for (int i = 0; i < 6; i++) begin
      ws_allowin = 1'b1; es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(1'b1, v_ld[i], 1'b1, 2'b00, 5'd3, {30'h0400_0000, v_ad[i]},
                        32'h1C00_0000 + 32'(i * 4), 1'b0);
      tick();
      es_to_ms_valid = 1'b0; data_sram_rdata = v_rd[i];
      #1;
      n_cmp++; if (ms_to_ds_result !== v_exp[i]) begin
        n_err++; $display("FAIL load_vec%0d result got %h want %h", i, ms_to_ds_result, v_exp[i]);
      end
      n_cmp++; if (ms_to_ws_valid !== 1'b1) begin
        n_err++; $display("FAIL load_vec%0d valid got %b want 1", i, ms_to_ws_valid);
      end
      $display("load_vec%0d: ld=%b addr=%0d rdata=%h result=%h", i, v_ld[i], v_ad[i], v_rd[i], ms_to_ds_result);
      tick();
    end
  endtask

  task automatic test_non_load();
    for (int nd = 0; nd < 2; nd++) begin
      ws_allowin = 1'b1; es_to_ms_valid = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
      es_to_ms_bus = mk(1'b0, 3'b001, 1'b1, 2'b01, 5'd7, 32'h1C00_0040, 32'h1C00_0200, nd[0]);
      tick();
      es_to_ms_valid = 1'b0;
      #1;
      n_cmp++; if (ms_to_ds_result !== 32'h1C00_0040) begin
        n_err++; $display("FAIL non_load%0d result got %h want 1c000040", nd, ms_to_ds_result);
      end
      n_cmp++; if (ms_to_ds_dest !== (nd == 0 ? 5'd7 : 5'd0)) begin
        n_err++; $display("FAIL non_load%0d bypass dest got %0d want %0d", nd, ms_to_ds_dest, (nd == 0 ? 7 : 0));
      end
      n_cmp++; if (ms_to_ws_bus[68:64] !== 5'd7) begin
        n_err++; $display("FAIL non_load%0d ws dest got %0d want 7", nd, ms_to_ws_bus[68:64]);
      end
      $display("non_load%0d: result=%h ds_dest=%0d", nd, ms_to_ds_result, ms_to_ds_dest);
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] want;
`ifdef MS_RDATA_HOLD_EN
    want = 32'hDEAD_BEEF;
`else
    want = 32'h0000_0000;
`endif
    ws_allowin = 1'b1; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, 3'b000, 1'b1, 2'b00, 5'd9, 32'h0000_1000, 32'h1C00_0100, 1'b0);
    tick();
    out_q.delete();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (ms_to_ds_result !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL stall first result got %h want deadbeef", ms_to_ds_result);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      data_sram_rdata = 32'h0;
      #1;
      n_cmp++; if (ms_to_ds_result !== want) begin
        n_err++; $display("FAIL stall%0d result got %h want %h", c, ms_to_ds_result, want);
      end
      n_cmp++; if ({ms_to_ws_valid, ms_allowin} !== 2'b10) begin
        n_err++; $display("FAIL stall%0d valid/allowin got %b want 10", c, {ms_to_ws_valid, ms_allowin});
      end
      $display("stall%0d: result=%h", c, ms_to_ds_result);
      tick();
    end
    ws_allowin = 1'b1;
    tick();
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin
      n_err++; $display("FAIL stall release valid got %b want 0", ms_to_ws_valid);
    end
    tick();
    n_cmp++; if (out_q.size() != 1 || out_q[0] !== 32'h1C00_0100) begin
      n_err++; $display("FAIL stall handoff count %0d want 1 (pc %h want 1c000100)", out_q.size(),
                        (out_q.size() > 0) ? out_q[0] : 32'h0);
    end
    $display("stall: handoffs=%0d", out_q.size());
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs[3];
    for (int i = 0; i < 3; i++) pcs[i] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    out_q.delete();
    ws_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      es_to_ms_valid = (i < 3);
      es_to_ms_bus = mk(1'b0, 3'b000, 1'b1, 2'b00, 5'(i + 1), 32'(i), (i < 3) ? pcs[i] : 32'h0, 1'b0);
      #1;
      if (i > 0) begin
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[31:0] !== pcs[i-1]) begin
          n_err++; $display("FAIL b2b%0d valid/pc got %b/%h want 1/%h", i, ms_to_ws_valid, ms_to_ws_bus[31:0], pcs[i-1]);
        end
        $display("b2b%0d: pc=%h", i - 1, ms_to_ws_bus[31:0]);
      end
      tick();
    end
    es_to_ms_valid = 1'b0;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b drain valid got %b want 0", ms_to_ws_valid);
    end
    n_cmp++; if (out_q.size() != 3 || out_q[0] !== pcs[0] || out_q[1] !== pcs[1] || out_q[2] !== pcs[2]) begin
      n_err++; $display("FAIL b2b handoff order count %0d want 3", out_q.size());
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_fin;
    logic [4:0]  exp_dest;
    for (int c = 0; c < 400; c++) begin
      ws_allowin      = ($urandom_range(0, 3) != 0);
      es_to_ms_valid  = ($urandom_range(0, 3) != 0);
      es_to_ms_bus    = mk($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 1'($urandom),
                           2'($urandom), 5'($urandom), $urandom, $urandom, ($urandom_range(0, 4) == 0));
      data_sram_rdata = $urandom;
      #1;
      exp_dest = (m_valid && !m_bus[0]) ? m_bus[69:65] : 5'd0;
      n_cmp++; if ({ms_to_ws_valid, ms_allowin} !== {m_valid, !m_valid || ws_allowin}) begin
        n_err++; $display("FAIL rand%0d valid/allowin got %b want %b", c, {ms_to_ws_valid, ms_allowin},
                          {m_valid, !m_valid || ws_allowin});
      end
      n_cmp++; if (ms_to_ds_dest !== exp_dest) begin
        n_err++; $display("FAIL rand%0d ds_dest got %0d want %0d", c, ms_to_ds_dest, exp_dest);
      end
      if (m_valid) begin
        exp_fin = m_final();
        n_cmp++; if (ms_to_ws_bus !== {m_bus[72], m_bus[69:65], exp_fin, m_bus[32:1]}) begin
          n_err++; $display("FAIL rand%0d ws_bus got %h want %h", c, ms_to_ws_bus,
                            {m_bus[72], m_bus[69:65], exp_fin, m_bus[32:1]});
        end
        n_cmp++; if (ms_to_ds_result !== exp_fin || debug_ms_load_data !== m_load()) begin
          n_err++; $display("FAIL rand%0d result/load got %h/%h want %h/%h", c, ms_to_ds_result,
                            debug_ms_load_data, exp_fin, m_load());
        end
        $display("rand%0d: pc=%h result=%h ws_allowin=%b", c, debug_ms_pc, ms_to_ds_result, ws_allowin);
      end else begin
        $display("rand%0d: empty", c);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ws_allowin = 1'b1; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, 3'b000, 1'b1, 2'b00, 5'd12, 32'h0000_2000, 32'h1C00_0300, 1'b0);
    tick();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    tick();
    #1;
    n_cmp++; if (ms_to_ds_dest !== 5'd12) begin
      n_err++; $display("FAIL async pre ds_dest got %0d want 12", ms_to_ds_dest);
    end
    resetn = 1'b0;
    #1;
    n_cmp++; if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin
      n_err++; $display("FAIL async valid/allowin got %b want 01", {ms_to_ws_valid, ms_allowin});
    end
    n_cmp++; if (ms_to_ds_dest !== 5'd0) begin
      n_err++; $display("FAIL async ds_dest got %0d want 0", ms_to_ds_dest);
    end
    $display("async_reset: valid=%b allowin=%b ds_dest=%0d", ms_to_ws_valid, ms_allowin, ms_to_ds_dest);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin
      n_err++; $display("FAIL async release valid got %b want 0", ms_to_ws_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_vectors();
    test_non_load();
    test_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
